// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the 8-bit MIPS-style core
// Contents: datapath widths, the NOP encoding, fetch FSM state codes.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 8;

  localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 8'h00;

  // Raw codes kept as plain constants so legacy blocks can compare against them.
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    BOOT   = ST_BOOT,
    FETCH  = ST_FETCH,
    HALTED = ST_HALTED
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush
// Ports: clk, rst (async, active-high); load captures d_instr/d_pc and sets valid;
//        flush clears valid (wins over load); neither asserted holds everything.
//        valid/instr/pc are the registered IF/ID contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // A flush only drops valid; instr/pc are meaningless once valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, next-PC mux, fetch FSM, counter
// Ports: clk, rst (async, active-high); stall holds PC and IF/ID; redirect/redirect_pc
//        load a branch target and flush IF/ID; imem_addr = pc, imem_data read back in
//        the same cycle; if_valid/if_instr/if_pc = IF/ID contents; halted after
//        HALT_INSTR is fetched; fetch_count = saturating count of accepted fetches.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = CPU_ADDR_W,
  parameter int                 INSTR_W    = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1,
  parameter int                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              flush;
  logic              is_halt;

  assign imem_addr = pc;
  assign is_halt   = (imem_data == HALT_INSTR);

  // redirect beats stall: an older branch squashes whatever decode is stalling on.
  // In HALTED the HALT instruction drains out of IF/ID on the first unstalled cycle.
  assign accept = (state == FETCH) && !redirect && !stall;
  assign flush  = redirect || (state == BOOT) || ((state == HALTED) && !stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      state  <= FETCH;
      halted <= 1'b0;
    end else if (state == BOOT) begin
      state <= FETCH;
    end else if (accept) begin
      if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
      // HALT is still handed downstream; only the PC stops advancing.
      if (is_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .flush  (flush),
    .d_instr(imem_data),
    .d_pc   (pc),
    .valid  (if_valid),
    .instr  (if_instr),
    .pc     (if_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect;
  logic [7:0]  redirect_pc, imem_addr, imem_data, if_instr, if_pc;
  logic        if_valid, halted;
  logic [15:0] fetch_count;
  logic [7:0]  mem [256];

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .halted(halted), .fetch_count(fetch_count)
  );

  logic        rst2, valid2, halted2;
  logic [7:0]  addr2, data2, instr2, pc2;
  logic [15:0] cnt2;
  assign data2 = 8'h00;

  fetch_stage #(.RESET_PC(8'hFE), .HALT_INSTR(8'hAA)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0), .redirect_pc(8'h00),
    .imem_addr(addr2), .imem_data(data2), .if_valid(valid2), .if_instr(instr2),
    .if_pc(pc2), .halted(halted2), .fetch_count(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of what fetch should have done so far.
  logic [7:0]  m_pc;
  bit          m_boot, m_valid, m_halted, m_last_stall, mon_en;
  int          m_count;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  task automatic model_reset();
    m_pc = 8'h00; m_boot = 1; m_valid = 0; m_halted = 0; m_count = 0;
    m_last_stall = 0; exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic step(input bit s, input bit r, input logic [7:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    m_last_stall = s;
    if (m_boot) begin
      m_boot = 0; m_valid = 0;
      if (r) m_pc = rpc;
    end else if (r) begin
      m_pc = rpc; m_valid = 0; m_halted = 0;
    end else if (s) begin
    end else if (m_halted) begin
      m_valid = 0;
    end else begin
      exp_q.push_back({mem[m_pc], m_pc});
      m_valid = 1;
      if (m_count < 65535) m_count++;
      if (mem[m_pc] == 8'hFF) m_halted = 1;
      else m_pc = m_pc + 8'd1;
    end
    @(negedge clk);
  endtask

  // Monitor: checks state every cycle and pops the scoreboard on each newly
  // presented instruction; a stalled IF/ID must still show the last one.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_valid", if_valid, m_valid);
      check("halted", halted, m_halted);
      check("fetch_count", fetch_count, m_count);
      if (if_valid && !m_last_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          check("if_instr", if_instr, last_exp[15:8]);
          check("if_pc", if_pc, last_exp[7:0]);
        end
      end else if (if_valid) begin
        check("held_instr", if_instr, last_exp[15:8]);
        check("held_pc", if_pc, last_exp[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] prog [7];
    logic [7:0] e;
    prog = '{8'h1b, 8'h73, 8'h4e, 8'hc5, 8'h0c, 8'h59, 8'hFF};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 7; i++) mem[i] = prog[i];
    rst = 1; rst2 = 1; stall = 0; redirect = 0; redirect_pc = 0; mon_en = 0;
    last_exp = '0;
    #12;
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_halted", halted, 0);
    check("rst_count", fetch_count, 0);
    check("rst_addr", imem_addr, 0);

    @(negedge clk); #2;
    rst = 0; model_reset(); mon_en = 1;

    // Straight-line program to HALT, then HALT drains.
    repeat (9) step(0, 0, 8'h00);
    check("count_after_prog", fetch_count, 7);
    // Restart from 0 out of HALTED, then stall while 4e sits in IF/ID.
    step(0, 1, 8'h00);
    repeat (3) step(0, 0, 8'h00);
    repeat (3) step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    // Redirect to 4 while if_pc==1.
    step(0, 1, 8'h00);
    repeat (2) step(0, 0, 8'h00);
    step(0, 1, 8'h04);
    step(0, 0, 8'h00);
    // redirect with stall: redirect wins; redirect to current pc re-fetches it.
    step(1, 1, 8'h02);
    step(0, 0, 8'h00);
    step(0, 1, m_pc);
    step(0, 0, 8'h00);

    // Random program and random stall/redirect traffic.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
    #1;
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset mid-run: no clock edge needed.
    @(negedge clk);
    mon_en = 0;
    #2 rst = 1;
    #1;
    check("arst_valid", if_valid, 0);
    check("arst_instr", if_instr, 0);
    check("arst_pc", if_pc, 0);
    check("arst_halted", halted, 0);
    check("arst_count", fetch_count, 0);
    check("arst_addr", imem_addr, 0);

    // Second instance: RESET_PC=FE over NOPs, PC wraps FF -> 00.
    @(negedge clk); #2 rst2 = 0;
    @(negedge clk);
    check("w_boot_valid", valid2, 0);
    check("w_boot_addr", addr2, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = 8'hFE + 8'(i);
      check("w_valid", valid2, 1);
      check("w_if_pc", pc2, e);
      check("w_instr", instr2, 0);
      check("w_count", cnt2, i + 1);
      e = e + 8'd1;
      check("w_addr", addr2, e);
    end
    #2 rst2 = 1;
    #1;
    check("w_arst_valid", valid2, 0);
    check("w_arst_pc", pc2, 0);
    check("w_arst_addr", addr2, 8'hFE);
    check("w_arst_count", cnt2, 0);
    check("w_arst_halted", halted2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
